rv32_pipe_core: RTL and testbench

Five-stage in-order pipelined RV32I-subset processor (IF, ID, EX, MEM, WB) with on-chip instruction memory, data memory and register file. Includes EX/MEM forwarding, load-use hazard stall, and branch resolution in ID with IF flush. Top-level compute block; the bench preloads memories and registers hierarchically and observes PC, registers and data memory.

---
 rtl/rv32_pipe_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rv32_pipe_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_pipe_core.sv
// rv32_pipe_core: five-stage in-order RV32I-subset pipeline (IF, ID, EX, MEM, WB)
// with on-chip instruction memory, data memory and register file.
// EX operands are forwarded from EX/MEM and MEM/WB; a load followed by a
// dependent instruction stalls once; beq resolves in ID and flushes IF/ID.
// Build macro CPU_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o counters.
module rv32_pipe_core #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    use_imm;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                   use_imm: 1'b0, alu_op: ALU_ADD};

    // Storage arrays; contents are loaded from outside before a run.
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    // Pipeline state
    logic [31:0] pc;
    logic [31:0] ifid_pc, ifid_instr;
    ctrl_t       idex_ctrl;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [31:0] idex_rs1_val, idex_rs2_val, idex_imm;
    logic        exmem_reg_write, exmem_mem_read, exmem_mem_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result, exmem_store_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;

    // ID stage signals
    logic [6:0]  id_opcode, id_f7;
    logic [2:0]  id_f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    ctrl_t       id_ctrl;
    logic        id_is_beq;
    logic [31:0] id_imm, id_rs1_val, id_rs2_val;
    logic        branch_hit, stall, flush;

    // EX / MEM stage signals
    logic [31:0] fwd_a, fwd_b, op_b, ex_result, mem_rdata;

    assign id_opcode = ifid_instr[6:0];
    assign id_rd     = ifid_instr[11:7];
    assign id_f3     = ifid_instr[14:12];
    assign id_rs1    = ifid_instr[19:15];
    assign id_rs2    = ifid_instr[24:20];
    assign id_f7     = ifid_instr[31:25];

    // Decode: unrecognised encodings fall through with all controls off (NOP).
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        id_ctrl   = CTRL_NOP;
        id_is_beq = 1'b0;
        id_imm    = '0;
        case (id_opcode)
            OP_REG: begin
                id_ctrl.reg_write = 1'b1;
                case ({id_f7, id_f3})
                    {7'b0000000, 3'b000}: id_ctrl.alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: id_ctrl.alu_op = ALU_SUB;
                    {7'b0000000, 3'b111}: id_ctrl.alu_op = ALU_AND;
                    {7'b0000000, 3'b100}: id_ctrl.alu_op = ALU_XOR;
                    {7'b0000000, 3'b001}: id_ctrl.alu_op = ALU_SLL;
                    {7'b0000001, 3'b000}: id_ctrl.alu_op = ALU_MUL;
                    default:              id_ctrl.reg_write = 1'b0;
                endcase
            end
            OP_IMM: begin
                id_imm          = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                id_ctrl.use_imm = 1'b1;
                if (id_f3 == 3'b000) begin
                    id_ctrl.reg_write = 1'b1;
                end else if (id_f3 == 3'b101 && id_f7 == 7'b0100000) begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_op    = ALU_SRA;
                end
            end
            OP_LOAD: begin
                if (id_f3 == 3'b010) begin
                    id_imm            = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.mem_read  = 1'b1;
                    id_ctrl.use_imm   = 1'b1;
                end
            end
            OP_STORE: begin
                if (id_f3 == 3'b010) begin
                    id_imm            = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.use_imm   = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (id_f3 == 3'b000) begin
                    id_imm    = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                 ifid_instr[30:25], ifid_instr[11:8], 1'b0};
                    id_is_beq = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register read with x0 forced to zero and the WB write bypassed into ID.
    always_comb begin
        id_rs1_val = rf[id_rs1];
        id_rs2_val = rf[id_rs2];
        if (id_rs1 == 5'd0)                                id_rs1_val = '0;
        else if (memwb_reg_write && memwb_rd == id_rs1)    id_rs1_val = memwb_data;
        if (id_rs2 == 5'd0)                                id_rs2_val = '0;
        else if (memwb_reg_write && memwb_rd == id_rs2)    id_rs2_val = memwb_data;
    end

    // A stall outranks a taken branch; the branch is re-evaluated next cycle.
    assign branch_hit = id_is_beq && (id_rs1_val == id_rs2_val);
    assign stall      = idex_ctrl.mem_read && (idex_rd != 5'd0) &&
                        (idex_rd == id_rs1 || idex_rd == id_rs2);
    assign flush      = branch_hit && !stall && start_i;

    // PC and IF/ID: hold on stall; insert a NOP when flushing or when not running.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (!rst_i) begin
            pc         <= '0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
        end else if (!stall) begin
            if (start_i) pc <= flush ? ifid_pc + id_imm : pc + 32'd4;
            if (flush || !start_i) begin
                ifid_pc    <= '0;
                ifid_instr <= '0;
            end else begin
                ifid_pc    <= pc;
                ifid_instr <= imem[pc[IA_W+1:2]];
            end
        end
    end

    // ID/EX: a stall turns the slot into a bubble by zeroing its controls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ctrl    <= CTRL_NOP;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_rd      <= '0;
            idex_rs1_val <= '0;
            idex_rs2_val <= '0;
            idex_imm     <= '0;
        end else begin
            idex_ctrl    <= stall ? CTRL_NOP : id_ctrl;
            idex_rs1     <= id_rs1;
            idex_rs2     <= id_rs2;
            idex_rd      <= id_rd;
            idex_rs1_val <= id_rs1_val;
            idex_rs2_val <= id_rs2_val;
            idex_imm     <= id_imm;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = idex_rs1_val;
        fwd_b = idex_rs2_val;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)      fwd_a = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1) fwd_a = memwb_data;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)      fwd_b = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2) fwd_b = memwb_data;
    end

    assign op_b = idex_ctrl.use_imm ? idex_imm : fwd_b;

    // ALU; all arithmetic wraps modulo 2^32, mul keeps the low word.
    always_comb begin
        case (idex_ctrl.alu_op)
            ALU_SUB: ex_result = fwd_a - op_b;
            ALU_AND: ex_result = fwd_a & op_b;
            ALU_XOR: ex_result = fwd_a ^ op_b;
            ALU_SLL: ex_result = fwd_a << op_b[4:0];
            ALU_SRA: ex_result = $signed(fwd_a) >>> op_b[4:0];
            ALU_MUL: ex_result = fwd_a * op_b;
            default: ex_result = fwd_a + op_b;
        endcase
    end

    // EX/MEM register; store data carries the forwarded rs2 value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exmem_reg_write  <= 1'b0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_rd         <= '0;
            exmem_result     <= '0;
            exmem_store_data <= '0;
        end else begin
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_rd         <= idex_rd;
            exmem_result     <= ex_result;
            exmem_store_data <= fwd_b;
        end
    end

    // Word-indexed data memory; upper address bits are ignored so addresses wrap.
    assign mem_rdata = dmem[exmem_result[DA_W+1:2]];

    // Data memory write port.
    always_ff @(posedge clk_i) begin
        // NOTE: memory arrays carry no reset; their contents are loaded externally.
        if (exmem_mem_write) dmem[exmem_result[DA_W+1:2]] <= exmem_store_data;
    end

    // MEM/WB register selects load data or the ALU result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memwb_reg_write <= 1'b0;
            memwb_rd        <= '0;
            memwb_data      <= '0;
        end else begin
            memwb_reg_write <= exmem_reg_write;
            memwb_rd        <= exmem_rd;
            memwb_data      <= exmem_mem_read ? mem_rdata : exmem_result;
        end
    end

    // Register file write in WB; x0 is never written.
    always_ff @(posedge clk_i) begin
        if (memwb_reg_write && memwb_rd != 5'd0) rf[memwb_rd] <= memwb_data;
    end

`ifdef CPU_PERF_CNT_EN
    // Performance counters; a stall that coincides with a taken branch is not counted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && !branch_hit) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush)                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_pipe_core.sv
// tb_rv32_pipe_core: directed bench for rv32_pipe_core. Programs, registers and
// data memory are loaded hierarchically; results are read from the register
// file, data memory, PC and the hazard strobes.
module tb_rv32_pipe_core;

    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;
`ifdef CPU_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    rv32_pipe_core dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i)
`ifdef CPU_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int stalls;
    int flushes;
    logic [31:0] pc_trace [64];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;     // preset x5
        logic [31:0] b;     // preset x6
        int          rd;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd, input logic [6:0] op);
        return {imm, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
    endfunction

    function automatic logic [31:0] sw(input int rs2, input int rs1, input logic [11:0] imm);
        return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq(input int rs1, input int rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Enter reset and clear all storage while the pipeline is held.
    task automatic enter_reset();
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
        for (int i = 0; i < 32; i++)  dut.dmem[i] = 32'h0;
        for (int i = 0; i < 32; i++)  dut.rf[i]   = 32'h0;
        @(negedge clk_i);
    endtask

    task automatic release_run();
        rst_i   = 1'b1;
        start_i = 1'b1;
    endtask

    // Run n clock edges, sampling PC and hazard strobes between edges.
    task automatic run(input int n);
        stalls  = 0;
        flushes = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            pc_trace[i] = dut.pc;
            if (dut.stall) stalls++;
            if (dut.flush) flushes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"srai_1",   enc_i(12'h401, 5, 3'b101, 7, 7'b0010011), 32'hFFFF_FFF8, 32'd3, 7,  32'hFFFF_FFFC};
        vecs[1]  = '{"srai_31",  enc_i(12'h41F, 5, 3'b101, 16, 7'b0010011), 32'hFFFF_FFF8, 32'd3, 16, 32'hFFFF_FFFF};
        vecs[2]  = '{"mul_sq",   enc_r(7'b0000001, 6, 6, 3'b000, 8),  32'hFFFF_FFF8, 32'd3, 8,  32'd9};
        vecs[3]  = '{"mul_neg",  enc_r(7'b0000001, 5, 5, 3'b000, 17), 32'hFFFF_FFF8, 32'd3, 17, 32'd64};
        vecs[4]  = '{"mul_wrap", enc_r(7'b0000001, 6, 5, 3'b000, 8),  32'h0001_0000, 32'h0001_0000, 8, 32'd0};
        vecs[5]  = '{"xor",      enc_r(7'b0000000, 5, 6, 3'b100, 9),  32'hFFFF_FFF8, 32'd3, 9,  32'hFFFF_FFFB};
        vecs[6]  = '{"sll",      enc_r(7'b0000000, 6, 6, 3'b001, 10), 32'hFFFF_FFF8, 32'd3, 10, 32'd24};
        vecs[7]  = '{"and",      enc_r(7'b0000000, 6, 5, 3'b111, 11), 32'hFFFF_FFF8, 32'd3, 11, 32'd0};
        vecs[8]  = '{"add_wrap", enc_r(7'b0000000, 6, 5, 3'b000, 12), 32'h7FFF_FFFF, 32'd1, 12, 32'h8000_0000};
        vecs[9]  = '{"sub",      enc_r(7'b0100000, 6, 5, 3'b000, 13), 32'hFFFF_FFF8, 32'd3, 13, 32'hFFFF_FFF5};
        vecs[10] = '{"sub_wrap", enc_r(7'b0100000, 6, 5, 3'b000, 13), 32'd0, 32'd1, 13, 32'hFFFF_FFFF};
        vecs[11] = '{"addi_neg", addi(14, 5, 12'hFFF),                32'hFFFF_FFF8, 32'd3, 14, 32'hFFFF_FFF7};
        vecs[12] = '{"or_is_nop", enc_r(7'b0000000, 6, 5, 3'b110, 15), 32'hFFFF_FFF8, 32'd3, 15, 32'd0};

        // Reset state, then free-running fetch of an all-zero instruction memory.
        enter_reset();
        check("reset_pc", dut.pc, 32'd0);
        check("reset_ifid", dut.ifid_instr, 32'd0);
        dut.dmem[0] = 32'hDEAD_BEEF;
        dut.rf[1]   = 32'h0000_1234;
        release_run();
        run(4);
        for (int i = 0; i < 4; i++) check($sformatf("pc_step%0d", i), pc_trace[i], 32'(4 * (i + 1)));
        start_i = 1'b0;
        run(2);
        check("pc_hold_no_start", pc_trace[1], 32'd16);
        check("dmem_untouched", dut.dmem[0], 32'hDEAD_BEEF);
        check("rf_untouched", dut.rf[1], 32'h0000_1234);

        // Single-instruction ALU vectors.
        for (int v = 0; v < 13; v++) begin
            enter_reset();
            dut.imem[0] = vecs[v].instr;
            dut.rf[5]   = vecs[v].a;
            dut.rf[6]   = vecs[v].b;
            release_run();
            run(10);
            check(vecs[v].name, dut.rf[vecs[v].rd], vecs[v].exp);
        end

        // Back-to-back dependencies resolved by forwarding only.
        enter_reset();
        dut.imem[0] = addi(1, 0, 12'd10);
        dut.imem[1] = enc_r(7'b0000000, 1, 1, 3'b000, 2);
        dut.imem[2] = enc_r(7'b0100000, 1, 2, 3'b000, 3);
        release_run();
        run(12);
        check("fwd_x1", dut.rf[1], 32'd10);
        check("fwd_x2", dut.rf[2], 32'd20);
        check("fwd_x3", dut.rf[3], 32'd10);
        check("fwd_stalls", 32'(stalls), 32'd0);

        // Load-use: one stall cycle, PC held for that cycle.
        enter_reset();
        dut.dmem[0] = 32'd5;
        dut.imem[0] = lw(1, 0, 12'd0);
        dut.imem[1] = addi(2, 1, 12'd3);
        release_run();
        run(12);
        check("lu_x1", dut.rf[1], 32'd5);
        check("lu_x2", dut.rf[2], 32'd8);
        check("lu_stalls", 32'(stalls), 32'd1);
        check("lu_pc_held", pc_trace[2], 32'd8);
        check("lu_pc_resume", pc_trace[3], 32'd12);
`ifdef CPU_PERF_CNT_EN
        check("lu_stall_cnt", stall_cnt_o, 32'd1);
`endif

        // Taken beq skips one instruction and flushes once.
        enter_reset();
        dut.imem[0] = addi(1, 0, 12'd1);
        dut.imem[1] = addi(2, 0, 12'd1);
        dut.imem[4] = beq(1, 2, 13'd8);
        dut.imem[5] = addi(3, 0, 12'd99);
        dut.imem[6] = addi(4, 0, 12'd7);
        release_run();
        run(14);
        check("br_x3_skipped", dut.rf[3], 32'd0);
        check("br_x4", dut.rf[4], 32'd7);
        check("br_flushes", 32'(flushes), 32'd1);
`ifdef CPU_PERF_CNT_EN
        check("br_flush_cnt", flush_cnt_o, 32'd1);
`endif

        // Not-taken beq falls through without a flush.
        enter_reset();
        dut.imem[0] = addi(1, 0, 12'd1);
        dut.imem[4] = beq(1, 0, 13'd8);
        dut.imem[5] = addi(3, 0, 12'd99);
        release_run();
        run(12);
        check("bnt_x3", dut.rf[3], 32'd99);
        check("bnt_flushes", 32'(flushes), 32'd0);

        // Stores, load after store, address wrap, store-data forwarding, x0.
        enter_reset();
        dut.rf[6]   = 32'd3;
        dut.rf[7]   = 32'h55;
        dut.imem[0] = sw(6, 0, 12'd4);
        dut.imem[1] = lw(12, 0, 12'd4);
        dut.imem[2] = addi(0, 0, 12'd5);
        dut.imem[3] = addi(13, 0, 12'd1);
        dut.imem[4] = sw(7, 0, 12'd136);
        dut.imem[5] = addi(14, 0, 12'd42);
        dut.imem[6] = sw(14, 0, 12'd12);
        release_run();
        run(14);
        check("st_dmem1", dut.dmem[1], 32'd3);
        check("st_lw_x12", dut.rf[12], 32'd3);
        check("st_x0", dut.rf[0], 32'd0);
        check("st_x0_read", dut.rf[13], 32'd1);
        check("st_wrap_dmem2", dut.dmem[2], 32'h55);
        check("st_fwd_dmem3", dut.dmem[3], 32'd42);

        // Asynchronous reset in the middle of a run.
        enter_reset();
        dut.imem[0] = addi(1, 0, 12'd10);
        dut.imem[1] = enc_r(7'b0000000, 1, 1, 3'b000, 2);
        release_run();
        run(5);
        check("mid_pc_before", pc_trace[4], 32'd20);
        check("mid_wb_before", 32'(dut.memwb_reg_write), 32'd1);
        rst_i = 1'b0;
        #1;
        check("mid_pc_async", dut.pc, 32'd0);
        check("mid_wb_cleared", 32'(dut.memwb_reg_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
